// File: rtl/id_pkg.sv
// Shared definitions for the ID stage: control-bit positions, default widths and the ID/EX bundle.
`timescale 1ns/1ps
package id_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_AW     = $clog2(DEF_NREG);

  localparam int CTRL_RDWREN = 0;
  localparam int CTRL_LOAD   = 1;

  typedef struct packed {
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_XLEN-1:0]   rs1Data;
    logic [DEF_XLEN-1:0]   rs2Data;
    logic [DEF_XLEN-1:0]   imm;
    logic [DEF_AW-1:0]     rs1Addr;
    logic [DEF_AW-1:0]     rs2Addr;
    logic [DEF_AW-1:0]     rdAddr;
  } id_ex_t;

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero and asynchronous clear.
// With ID_WB_BYPASS_EN defined, a same-cycle writeback is forwarded onto the read ports.
`timescale 1ns/1ps
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wren,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wren && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  function automatic logic [XLEN-1:0] readPort(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = r_regs[a];
`ifdef ID_WB_BYPASS_EN
    if (i_wren && (i_waddr == a)) begin
      v = i_wdata;
    end
`endif
    if (a == '0) begin
      v = '0;
    end
    return v;
  endfunction

  assign o_rdata1 = readPort(i_raddr1);
  assign o_rdata2 = readPort(i_raddr2);

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with load-use hazard detection and the ID/EX pipeline register.
// ID_WB_BYPASS_EN selects writeback bypass; otherwise a same-cycle WB match costs one bubble.
`timescale 1ns/1ps
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int CTRL_W = DEF_CTRL_W,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [XLEN-1:0]   i_imm,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic              i_flush,
  input  logic              i_ex_ready,
  input  logic              i_wb_wren,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [AW-1:0]     o_rs1_addr,
  output logic [AW-1:0]     o_rs2_addr,
  output logic [AW-1:0]     o_rd_addr
);

  logic [AW-1:0]     w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]   w_rs1_data, w_rs2_data;
  logic              w_load_hazard, w_wb_hazard, w_hazard;
  logic              w_unused;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_imm, r_rs1_data, r_rs2_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [AW-1:0]     r_rs1_addr, r_rs2_addr, r_rd_addr;

  assign w_rs1    = i_instr[15 +: AW];
  assign w_rs2    = i_instr[20 +: AW];
  assign w_rd     = i_instr[7 +: AW];
  assign w_unused = &{1'b0, i_instr};

  id_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wren   (i_wb_wren),
    .i_waddr  (i_wb_addr),
    .i_wdata  (i_wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  assign w_load_hazard = i_valid & r_valid & r_ctrl[CTRL_LOAD] & (r_rd_addr != '0) &
                         ((i_rs1_used & (w_rs1 == r_rd_addr)) |
                          (i_rs2_used & (w_rs2 == r_rd_addr)));

`ifdef ID_WB_BYPASS_EN
  assign w_wb_hazard = 1'b0;
`else
  // Without the bypass the array only holds the WB value after the edge, so wait one cycle.
  assign w_wb_hazard = i_valid & i_wb_wren & (i_wb_addr != '0) &
                       ((i_rs1_used & (w_rs1 == i_wb_addr)) |
                        (i_rs2_used & (w_rs2 == i_wb_addr)));
`endif

  assign w_hazard = w_load_hazard | w_wb_hazard;
  assign o_ready  = i_flush | (i_ex_ready & ~w_hazard);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_ctrl     <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_ex_ready) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
      end else begin
        r_valid    <= i_valid;
        r_pc       <= i_pc;
        r_imm      <= i_imm;
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_ctrl     <= i_ctrl;
        r_rs1_addr <= w_rs1;
        r_rs2_addr <= w_rs2;
        r_rd_addr  <= w_rd;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_imm      = r_imm;
  assign o_rs1_data = r_rs1_data;
  assign o_rs2_data = r_rs2_data;
  assign o_ctrl     = r_ctrl;
  assign o_rs1_addr = r_rs1_addr;
  assign o_rs2_addr = r_rs2_addr;
  assign o_rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed scenarios plus random traffic against an architectural model.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, o_ready;
  logic [31:0] i_instr, i_pc, i_imm, i_wb_data;
  logic [15:0] i_ctrl;
  logic        i_rs1_used, i_rs2_used, i_flush, i_ex_ready, i_wb_wren;
  logic [4:0]  i_wb_addr;
  logic        o_valid;
  logic [31:0] o_pc, o_imm, o_rs1_data, o_rs2_data;
  logic [15:0] o_ctrl;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_ctrl     (i_ctrl),
    .i_imm      (i_imm),
    .i_rs1_used (i_rs1_used),
    .i_rs2_used (i_rs2_used),
    .i_flush    (i_flush),
    .i_ex_ready (i_ex_ready),
    .i_wb_wren  (i_wb_wren),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_valid    (o_valid),
    .o_pc       (o_pc),
    .o_imm      (o_imm),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
    .o_ctrl     (o_ctrl),
    .o_rs1_addr (o_rs1_addr),
    .o_rs2_addr (o_rs2_addr),
    .o_rd_addr  (o_rd_addr)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1Used, rs2Used;
    logic [31:0] pc, imm;
    logic [15:0] ctrl;
    logic        flush, exReady, wbWren;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
  } stim_t;

  id_ex_t      expQ[$];
  logic [31:0] modelRegs [32];
  logic        mValid, mLoad;
  logic [4:0]  mRd;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Architectural register read: x0 is zero, same-cycle WB is visible only with the bypass.
  function automatic logic [31:0] modelRead(input logic [4:0] a, input stim_t s);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (s.wbWren && s.wbAddr == a) return s.wbData;
`endif
    return modelRegs[a];
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.valid = 1'b0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
    s.rs1Used = 1'b0; s.rs2Used = 1'b0;
    s.pc = '0; s.imm = '0; s.ctrl = '0;
    s.flush = 1'b0; s.exReady = 1'b1; s.wbWren = 1'b0;
    s.wbAddr = '0; s.wbData = '0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.valid   = ($urandom_range(0, 9) < 8);
    s.rs1     = 5'($urandom_range(0, 7));
    s.rs2     = 5'($urandom_range(0, 7));
    s.rd      = 5'($urandom_range(0, 7));
    s.rs1Used = 1'($urandom_range(0, 1));
    s.rs2Used = 1'($urandom_range(0, 1));
    s.pc      = $urandom;
    s.imm     = $urandom;
    s.ctrl    = 16'($urandom);
    s.ctrl[CTRL_LOAD] = ($urandom_range(0, 2) == 0);
    s.flush   = ($urandom_range(0, 9) == 0);
    s.exReady = ($urandom_range(0, 9) < 8);
    s.wbWren  = 1'($urandom_range(0, 1));
    s.wbAddr  = 5'($urandom_range(0, 7));
    s.wbData  = $urandom;
    return s;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) modelRegs[i] = '0;
    mValid = 1'b0;
    mLoad  = 1'b0;
    mRd    = '0;
    expQ.delete();
  endtask

  // Drives one cycle of inputs just after a rising edge, checks o_ready/o_valid, then advances the model.
  task automatic applyStimulus(input stim_t s, output logic accepted);
    logic [31:0] instr;
    logic        loadUse, wbUse, stall, expReady;
    id_ex_t      item;
    instr = $urandom;
    instr[19:15] = s.rs1;
    instr[24:20] = s.rs2;
    instr[11:7]  = s.rd;
    i_valid = s.valid; i_instr = instr; i_pc = s.pc; i_imm = s.imm; i_ctrl = s.ctrl;
    i_rs1_used = s.rs1Used; i_rs2_used = s.rs2Used; i_flush = s.flush; i_ex_ready = s.exReady;
    i_wb_wren = s.wbWren; i_wb_addr = s.wbAddr; i_wb_data = s.wbData;
    @(negedge clk);
    loadUse = mValid && mLoad && (mRd != 0) &&
              ((s.rs1Used && s.rs1 == mRd) || (s.rs2Used && s.rs2 == mRd));
`ifdef ID_WB_BYPASS_EN
    wbUse = 1'b0;
`else
    wbUse = s.wbWren && (s.wbAddr != 0) &&
            ((s.rs1Used && s.rs1 == s.wbAddr) || (s.rs2Used && s.rs2 == s.wbAddr));
`endif
    stall    = s.valid && (loadUse || wbUse);
    expReady = s.flush || (s.exReady && !stall);
    checkOutput("o_ready", 192'(o_ready), 192'(expReady));
    checkOutput("o_valid", 192'(o_valid), 192'(mValid));
    item.pc = s.pc; item.ctrl = s.ctrl; item.imm = s.imm;
    item.rs1Data = modelRead(s.rs1, s);
    item.rs2Data = modelRead(s.rs2, s);
    item.rs1Addr = s.rs1; item.rs2Addr = s.rs2; item.rdAddr = s.rd;
    @(posedge clk);
    if (s.flush) begin
      mValid = 1'b0;
    end else if (s.exReady) begin
      if (stall) begin
        mValid = 1'b0;
      end else begin
        mValid = s.valid;
        mLoad  = s.ctrl[CTRL_LOAD];
        mRd    = s.rd;
        if (s.valid) expQ.push_back(item);
      end
    end
    if (s.wbWren && s.wbAddr != 0) modelRegs[s.wbAddr] = s.wbData;
    accepted = expReady;
    #1;
  endtask

  // Presents an instruction until accepted and checks how many attempts it took.
  task automatic issue(input string name, input stim_t s, input int expAttempts);
    logic acc;
    int   attempts;
    acc = 1'b0;
    attempts = 0;
    while (!acc && attempts < 6) begin
      applyStimulus(s, acc);
      attempts++;
      s.wbWren = 1'b0;
    end
    checkOutput({"attempts_", name}, 192'(attempts), 192'(expAttempts));
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(idleStim(), acc);
  endtask

  // Monitor: compares whatever ID/EX presents against the oldest expected issue.
  initial begin
    id_ex_t got;
    forever begin
      @(negedge clk);
      if (!i_reset && o_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL idex_unexpected: got pc %0h expected no valid issue", o_pc);
        end else begin
          got.pc = o_pc; got.ctrl = o_ctrl; got.imm = o_imm;
          got.rs1Data = o_rs1_data; got.rs2Data = o_rs2_data;
          got.rs1Addr = o_rs1_addr; got.rs2Addr = o_rs2_addr; got.rdAddr = o_rd_addr;
          checkOutput("idex", 192'(got), 192'(expQ[0]));
          if (i_ex_ready || i_flush) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic  acc;
    i_reset = 1'b1;
    i_valid = 0; i_instr = 0; i_pc = 0; i_imm = 0; i_ctrl = 0;
    i_rs1_used = 0; i_rs2_used = 0; i_flush = 0; i_ex_ready = 1;
    i_wb_wren = 0; i_wb_addr = 0; i_wb_data = 0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 192'(o_valid), 192'(0));
    checkOutput("reset_pc", 192'(o_pc), 192'(0));
    checkOutput("reset_rs1", 192'(o_rs1_data), 192'(0));
    checkOutput("reset_ctrl", 192'(o_ctrl), 192'(0));
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] WB then read x5");
    s = idleStim(); s.wbWren = 1; s.wbAddr = 5; s.wbData = 32'hDEADBEEF;
    applyStimulus(s, acc);
    s = idleStim(); s.valid = 1; s.rs1 = 5; s.rs1Used = 1; s.rd = 1; s.pc = 32'h100; s.imm = 32'h4;
    issue("read_x5", s, 1);

    $display("[TB] load-use on x7");
    s = idleStim(); s.valid = 1; s.rd = 7; s.ctrl = 16'h0003; s.pc = 32'h104;
    issue("load_x7", s, 1);
    s = idleStim(); s.valid = 1; s.rs2 = 7; s.rs2Used = 1; s.rd = 2; s.ctrl = 16'h0001; s.pc = 32'h108;
    issue("use_x7", s, 2);

    $display("[TB] no stall for rd=x0 or unused rs2");
    s = idleStim(); s.valid = 1; s.rd = 0; s.ctrl = 16'h0002; s.pc = 32'h10C;
    issue("load_x0", s, 1);
    s = idleStim(); s.valid = 1; s.rs2 = 0; s.rs2Used = 1; s.rd = 3; s.pc = 32'h110;
    issue("use_x0", s, 1);
    s = idleStim(); s.valid = 1; s.rd = 7; s.ctrl = 16'h0003; s.pc = 32'h114;
    issue("load_x7b", s, 1);
    s = idleStim(); s.valid = 1; s.rs1 = 2; s.rs1Used = 1; s.rs2 = 7; s.rs2Used = 0; s.pc = 32'h118;
    issue("unused_x7", s, 1);

    $display("[TB] same-cycle WB x3 and read");
    s = idleStim(); s.valid = 1; s.rs1 = 3; s.rs1Used = 1; s.rd = 4; s.pc = 32'h11C;
    s.wbWren = 1; s.wbAddr = 3; s.wbData = 32'h12;
`ifdef ID_WB_BYPASS_EN
    issue("wb_x3", s, 1);
`else
    issue("wb_x3", s, 2);
`endif

    $display("[TB] EX backpressure then flush");
    s = idleStim(); s.valid = 1; s.rs1 = 5; s.rs1Used = 1; s.rd = 6; s.pc = 32'h120; s.imm = 32'h55;
    issue("before_hold", s, 1);
    s.pc = 32'h124; s.exReady = 0;
    for (int i = 0; i < 3; i++) applyStimulus(s, acc);
    s.flush = 1;
    applyStimulus(s, acc);
    idleCycles(2);

    $display("[TB] reset mid-stream");
    s = idleStim(); s.wbWren = 1; s.wbAddr = 1; s.wbData = 32'h0000ABCD;
    applyStimulus(s, acc);
    s = idleStim(); s.valid = 1; s.rs1 = 1; s.rs1Used = 1; s.rd = 2; s.pc = 32'h200;
    issue("read_x1", s, 1);
    i_valid = 0;
    i_reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", 192'(o_valid), 192'(0));
    clearModel();
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    s = idleStim(); s.valid = 1; s.rs1 = 1; s.rs1Used = 1; s.rd = 2; s.pc = 32'h204;
    issue("read_x1_after_reset", s, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) applyStimulus(randStim(), acc);
    idleCycles(3);
    checkOutput("scoreboard_drained", 192'(expQ.size()), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
